seg_scan_display: RTL and testbench

- Drives the board's 8-digit common-anode seven-segment display. It is fed by the display-value selector stage, which provides the 32-bit word to show: Syscall output, RAM word, PC, or performance counters.
- Double-buffers the incoming word so the display never shows a mix of old and new digits within one scan.
- Time-multiplexes the eight hex digits, with optional leading-zero blanking and a blink mode used to flag CPU halt.
- Runs on the undivided board clock, independent of the CPU clock selected by the divider.

---
 rtl/seg_scan_display_pkg.sv | 24 ++
 rtl/seg_scan_display_hex_to_seg.sv | 12 +
 rtl/seg_scan_display.sv | 158 +++++++++++++++
 tb/tb_seg_scan_display.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the seven-segment scan display.
//   NDIG     : number of digits scanned per frame
//   SEG_OFF  : segment pattern with every segment (and dp) dark
//   AN_OFF   : anode pattern with every digit disabled
//   HEX_SEG  : hex nibble -> gfedcba, active-high (inverted at the pins)
//   blink_phase_e : visible / dark half of the blink period
package seg_scan_display_pkg;

  localparam int         NDIG    = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Entry 15 is leftmost, entry 0 rightmost.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Hex nibble to active-low seven-segment decoder (combinational).
//   nibble : 4-bit hex value
//   seg_n  : gfedcba, active-low
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  import seg_scan_display_pkg::*;

  assign seg_n = ~HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit common-anode seven-segment scanner with a double-buffered
// display word, leading-zero blanking and a whole-display blink.
//   clk_in   : board clock (undivided)
//   RST      : asynchronous active-high reset
//   data_in  : word to show, nibble i on digit i (digit 0 rightmost)
//   load     : capture data_in this cycle
//   blank_lz : blank leading zero digits (digit 0 always lit)
//   blink    : blink the whole display
//   SEG      : active-low segments, bit7 = dp, bits6:0 = gfedcba
//   AN       : active-low one-hot digit enables
//
// Blink phase FSM:
//   state  | meaning
//   PH_ON  | display visible (also forced whenever blink=0)
//   PH_OFF | display dark, scan keeps running
module seg_scan_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);
  import seg_scan_display_pkg::*;

  localparam int              PW       = $clog2(REFRESH_DIV);
  localparam int              FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0]   PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0]   FRAME_TC = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]      LAST_DIG = 3'(NDIG - 1);

  logic [PW-1:0] presc_q;
  logic [2:0]    index_q;
  logic [31:0]   pending_q;
  logic [31:0]   shadow_q;
  logic          pend_valid_q;
  logic [FW-1:0] frame_q;
  blink_phase_e  phase_q, phase_d;

  logic          tc;
  logic          frame_end;
  logic          frame_wrap;
  logic          display_off;
  logic          lz_blank;
  logic [3:0]    nib;
  logic [6:0]    seg_n;
  logic [7:0]    seg_d;
  logic [7:0]    an_d;

  assign tc         = (presc_q == PRESC_TC);
  assign frame_end  = tc && (index_q == LAST_DIG);
  assign frame_wrap = frame_end && (frame_q == FRAME_TC);

  // Prescaler and digit index; the 3-bit index wraps 7 -> 0 on its own.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      index_q <= '0;
    end else if (tc) begin
      presc_q <= '0;
      index_q <= index_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Pending/shadow double buffer. Shadow only changes on a frame end so a
  // scan never mixes digits of two words; a load on the frame end itself
  // bypasses pending and supersedes whatever was waiting there.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      pending_q    <= '0;
      shadow_q     <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (load) pending_q <= data_in;
      if (frame_end) begin
        if (load) begin
          shadow_q     <= data_in;
          pend_valid_q <= 1'b0;
        end else if (pend_valid_q) begin
          shadow_q     <= pending_q;
          pend_valid_q <= 1'b0;
        end
      end else if (load) begin
        pend_valid_q <= 1'b1;
      end
    end
  end

  // Frames elapsed in the current blink half-period.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      frame_q <= '0;
    end else if (!blink) begin
      frame_q <= '0;
    end else if (frame_end) begin
      frame_q <= (frame_q == FRAME_TC) ? '0 : frame_q + FW'(1);
    end
  end

  // Blink phase: state register
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) phase_q <= PH_ON;
    else     phase_q <= phase_d;
  end

  // Blink phase: next state
  always_comb begin
    phase_d = phase_q;
    if (!blink) begin
      phase_d = PH_ON;
    end else if (frame_wrap) begin
      phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end
  end

  // Blink phase: output
  always_comb begin
    display_off = blink && (phase_q == PH_OFF);
  end

  assign nib = shadow_q[{index_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nib),
    .seg_n  (seg_n)
  );

  // Digit i is a leading zero when it and every digit to its left are zero.
  assign lz_blank = blank_lz && (index_q != 3'd0) &&
                    ((shadow_q >> {index_q, 2'b00}) == 32'd0);

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!(display_off || lz_blank)) begin
      an_d  = ~(8'b1 << index_q);
      seg_d = {1'b1, seg_n};
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      SEG <= SEG_OFF;
      AN  <= AN_OFF;
    end else begin
      SEG <= seg_d;
      AN  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with REFRESH_DIV=4, BLINK_FRAMES=2.
// Expected digit outputs are queued with the edge at which they must appear;
// each test task drains its own queue entries at the matching edge.
module tb_seg_scan_display;

  localparam int RDIV = 4;
  localparam int FRAME = 8 * RDIV;

  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [7:0]  SEG;
  logic [7:0]  AN;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         edge_n;
    logic [7:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t sb[$];

  seg_scan_display #(.REFRESH_DIV(RDIV), .BLINK_FRAMES(2)) dut (
    .clk_in   (clk_in),
    .RST      (RST),
    .data_in  (data_in),
    .load     (load),
    .blank_lz (blank_lz),
    .blink    (blink),
    .SEG      (SEG),
    .AN       (AN)
  );

  always #5 clk_in = ~clk_in;

  // Edges since reset release; edge k shows the output produced by edge k.
  always @(posedge clk_in or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_hex(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_an(input int d);
    logic [7:0] a;
    a = 8'hFF;
    a[d] = 1'b0;
    return a;
  endfunction

  // {AN, SEG} for digit d of word v.
  function automatic logic [15:0] exp_out(input logic [31:0] v, input int d, input bit blz);
    bit all_zero;
    logic [31:0] t;
    all_zero = 1'b1;
    for (int i = d; i < 8; i++) begin
      t = v >> (4 * i);
      if (t[3:0] != 4'h0) all_zero = 1'b0;
    end
    if (blz && d > 0 && all_zero) return 16'hFFFF;
    t = v >> (4 * d);
    return {exp_an(d), exp_hex(t[3:0])};
  endfunction

  // Mid-slot edge for digit d of frame f (frames start at edge 1).
  function automatic int slot_edge(input int f, input int d);
    return FRAME * f + RDIV * d + 2;
  endfunction

  function automatic int cur_frame();
    return (cyc - 1) / FRAME;
  endfunction

  task automatic push_exp(input int e, input logic [15:0] o, input string nm);
    exp_t x;
    x.edge_n = e;
    x.an     = o[15:8];
    x.seg    = o[7:0];
    x.name   = nm;
    sb.push_back(x);
  endtask

  task automatic goto_edge(input int k);
    do @(negedge clk_in); while (cyc < k);
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (AN !== 8'hFF || SEG !== 8'hFF) begin
      errors++;
      $display("FAIL reset_hold: AN=%h SEG=%h, required AN=ff SEG=ff", AN, SEG);
    end
    RST = 1'b0;
    push_exp(1, 16'hFEC0, "first_edge");
    push_exp(4, 16'hFEC0, "digit0_last");
    push_exp(5, 16'hFDC0, "digit1_first");
    for (int d = 2; d < 8; d++) push_exp(slot_edge(0, d), exp_out(0, d, 0), $sformatf("scan_d%0d", d));
    push_exp(FRAME + 1, 16'hFEC0, "wrap_d0");
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  endtask

  task automatic test_load_latency();
    exp_t e;
    int f;
    f = cur_frame() + 1;
    goto_edge(FRAME * f + 12);
    load = 1'b1; data_in = 32'h12345678;
    @(negedge clk_in);
    load = 1'b0;
    push_exp(slot_edge(f, 5), exp_out(0, 5, 0), "cur_frame_d5");
    push_exp(slot_edge(f, 7), exp_out(0, 7, 0), "cur_frame_d7");
    for (int d = 0; d < 8; d++)
      push_exp(slot_edge(f + 1, d), exp_out(32'h12345678, d, 0), $sformatf("latency_d%0d", d));
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    exp_t e;
    int g;
    g = cur_frame() + 1;
    goto_edge(FRAME * g + 4);
    load = 1'b1; data_in = 32'hAAAA0000;
    @(negedge clk_in);
    load = 1'b0;
    goto_edge(FRAME * g + 19);
    load = 1'b1; data_in = 32'h0000BEEF;
    @(negedge clk_in);
    load = 1'b0;
    push_exp(slot_edge(g, 7), exp_out(32'h12345678, 7, 0), "old_word_d7");
    for (int d = 0; d < 8; d++)
      push_exp(slot_edge(g + 1, d), exp_out(32'h0000BEEF, d, 0), $sformatf("overwrite_d%0d", d));
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  endtask

  task automatic test_frame_end_load();
    exp_t e;
    int h;
    h = cur_frame() + 1;
    goto_edge(FRAME * h + 9);
    load = 1'b1; data_in = 32'h00000077;
    @(negedge clk_in);
    load = 1'b0;
    goto_edge(FRAME * h + FRAME - 1);
    load = 1'b1; data_in = 32'h00000005;
    @(negedge clk_in);
    load = 1'b0;
    for (int f = h + 1; f <= h + 2; f++)
      for (int d = 0; d < 2; d++)
        push_exp(slot_edge(f, d), exp_out(32'h00000005, d, 0), $sformatf("fe_load_f%0d_d%0d", f - h, d));
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  endtask

  task automatic test_blank_lz();
    exp_t e;
    int j;
    logic [31:0] vals [2];
    vals[0] = 32'h00000050;
    vals[1] = 32'h00000000;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      j = cur_frame() + 1;
      goto_edge(FRAME * j + 3);
      load = 1'b1; data_in = vals[v];
      @(negedge clk_in);
      load = 1'b0;
      for (int d = 0; d < 8; d++)
        push_exp(slot_edge(j + 1, d), exp_out(vals[v], d, 1), $sformatf("blank_v%0d_d%0d", v, d));
      while (sb.size() > 0) begin
        @(negedge clk_in);
        if (cyc >= sb[0].edge_n) begin
          e = sb.pop_front();
          checks++;
          if (cyc != e.edge_n) begin
            errors++;
            $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
          end else if (AN !== e.an || SEG !== e.seg) begin
            errors++;
            $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    exp_t e;
    int k;
    bit lit;
    k = cur_frame() + 1;
    goto_edge(FRAME * k);
    blink = 1'b1;
    for (int f = 0; f < 6; f++) begin
      lit = (f % 4) < 2;
      push_exp(slot_edge(k + f, 0), lit ? exp_out(0, 0, 0) : 16'hFFFF, $sformatf("blink_f%0d_d0", f));
      push_exp(slot_edge(k + f, 3), lit ? exp_out(0, 3, 0) : 16'hFFFF, $sformatf("blink_f%0d_d3", f));
    end
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
    blink = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int m;
    m = cur_frame() + 1;
    goto_edge(FRAME * m + 2);
    load = 1'b1; data_in = 32'h12345678;
    @(negedge clk_in);
    load = 1'b0;
    goto_edge(FRAME * (m + 1) + 6);
    checks++;
    if (AN !== 8'hFD || SEG !== 8'hF8) begin
      errors++;
      $display("FAIL pre_reset_d1: AN=%h SEG=%h, required AN=fd SEG=f8", AN, SEG);
    end
    load = 1'b1; data_in = 32'h00000009;
    @(negedge clk_in);
    load = 1'b0;
    #2 RST = 1'b1;
    #1;
    checks++;
    if (AN !== 8'hFF || SEG !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: AN=%h SEG=%h, required AN=ff SEG=ff", AN, SEG);
    end
    @(negedge clk_in);
    RST = 1'b0;
    push_exp(1, 16'hFEC0, "restart_d0");
    push_exp(slot_edge(0, 7), exp_out(0, 7, 0), "restart_d7");
    push_exp(slot_edge(1, 0), exp_out(0, 0, 0), "pending_dropped");
    while (sb.size() > 0) begin
      @(negedge clk_in);
      if (cyc >= sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.edge_n) begin
          errors++;
          $display("FAIL %s: sampled at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
        end else if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL %s: AN=%h SEG=%h, required AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_overwrite();
    test_frame_end_load();
    test_blank_lz();
    test_blink();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
